regwb_arb: RTL and testbench

//  Write-port initiator for the 32x32 register file: merges main-pipeline writeback and multicycle-unit
//  (mul/div) results onto the single regwrite/wrreg/wrdata port. Pipeline writes have absolute priority;

---
 rtl/regwb_pkg.sv | 16 +
 rtl/regwb_arb_if.sv | 28 ++
 rtl/regwb_fifo.sv | 70 +++++++
 rtl/regwb_arb.sv | 97 +++++++++
 tb/tb_regwb_arb.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Entries carry a destination register and the data to be written there.
package regwb_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [31:0] reg_onehot(input logic [REG_W-1:0] r);
        return 32'd1 << r;
    endfunction
endpackage

// File: rtl/regwb_arb_if.sv
// Bundle of pipeline/multicycle inputs and register-file write port outputs.
// mc handshake: a transfer happens on a rising clk edge where mc_valid && mc_ready; no other signal gates it.
interface regwb_arb_if;
    import regwb_pkg::*;

    logic              pipe_valid;
    logic [REG_W-1:0]  pipe_reg;
    logic [DATA_W-1:0] pipe_data;
    logic              mc_valid;
    logic              mc_ready;
    logic [REG_W-1:0]  mc_reg;
    logic [DATA_W-1:0] mc_data;
    logic              regwrite;
    logic [REG_W-1:0]  wrreg;
    logic [DATA_W-1:0] wrdata;
    logic [31:0]       pend_mask;
    logic              stall_req;

    // master: the arbiter itself; slave: the pipeline / mul-div / regfile side
    modport master (
        input  pipe_valid, pipe_reg, pipe_data, mc_valid, mc_reg, mc_data,
        output mc_ready, regwrite, wrreg, wrdata, pend_mask, stall_req
    );
    modport slave (
        output pipe_valid, pipe_reg, pipe_data, mc_valid, mc_reg, mc_data,
        input  mc_ready, regwrite, wrreg, wrdata, pend_mask, stall_req
    );
endinterface

// File: rtl/regwb_fifo.sv
// Small FIFO of pending multicycle writebacks; exposes per-entry valid bits and
// destinations so the top can build the pending-register mask.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    output wb_entry_t                     head,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0]              valid,
    output logic [DEPTH-1:0][REG_W-1:0]   dests
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            dests[i] = mem[i].dest;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (do_push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/regwb_arb.sv
// Register-file write port arbiter: pipeline writes win, buffered multicycle
// results drain into idle slots, and a starvation counter requests a bubble.
module regwb_arb
    import regwb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    regwb_arb_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    wb_entry_t                   push_entry;
    wb_entry_t                   head;
    logic [CW-1:0]               count;
    logic                        full;
    logic                        empty;
    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0][REG_W-1:0] dests;
    logic                        pipe_win;
    logic                        push;
    logic                        pop;
    logic [SW-1:0]               starve_cnt;
    logic [SW-1:0]               starve_next;

    assign bus.mc_ready = rst_n && !full;
    assign pipe_win     = bus.pipe_valid && (bus.pipe_reg != REG_ZERO);
    // $zero results complete the handshake but never occupy a slot.
    assign push         = bus.mc_valid && bus.mc_ready && (bus.mc_reg != REG_ZERO);
    assign pop          = rst_n && !pipe_win && !empty;
    assign push_entry   = '{dest: bus.mc_reg, data: bus.mc_data};

    regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .valid      (valid),
        .dests      (dests)
    );

    always_comb begin
        bus.pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                bus.pend_mask = bus.pend_mask | reg_onehot(dests[i]);
            end
        end
        bus.pend_mask[0] = 1'b0;
    end

    always_comb begin
        starve_next = starve_cnt;
        if (empty || pop) begin
            starve_next = '0;
        end else if (pipe_win && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_next = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt    <= '0;
            bus.stall_req <= 1'b0;
        end else begin
            starve_cnt    <= starve_next;
            bus.stall_req <= (starve_next == SW'(STARVE_MAX));
        end
    end

    // Write address/data hold their last value on idle slots.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.regwrite <= 1'b0;
            bus.wrreg    <= '0;
            bus.wrdata   <= '0;
        end else if (pipe_win) begin
            bus.regwrite <= 1'b1;
            bus.wrreg    <= bus.pipe_reg;
            bus.wrdata   <= bus.pipe_data;
        end else if (pop) begin
            bus.regwrite <= 1'b1;
            bus.wrreg    <= head.dest;
            bus.wrdata   <= head.data;
        end else begin
            bus.regwrite <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regwb_arb.sv
// Directed bench for regwb_arb: reset, pipe writes, idle drain, full FIFO,
// starvation stall and $zero handling, all against hand-computed values.
module tb_regwb_arb;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regwb_arb_if bus ();

    regwb_arb #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change 1ns after the rising edge, outputs sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pipe(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.pipe_valid = v;
        bus.pipe_reg   = r;
        bus.pipe_data  = d;
    endtask

    task automatic drive_mc(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.mc_valid = v;
        bus.mc_reg   = r;
        bus.mc_data  = d;
    endtask

    // hazard unit guarantee: a pipeline write never targets a pending register
    always @(negedge clk) begin
        if (rst_n && bus.pipe_valid) begin
            check("no_collide", {31'd0, bus.pend_mask[bus.pipe_reg]}, 32'd0);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive_pipe(1'b1, 5'd5, 32'h1);
        drive_mc(1'b0, 5'd0, 32'h0);

        // reset held 3 cycles with pipe_valid asserted
        repeat (3) tick();
        check("rst_regwrite", {31'd0, bus.regwrite}, 32'd0);
        check("rst_pend", bus.pend_mask, 32'd0);
        check("rst_mc_ready", {31'd0, bus.mc_ready}, 32'd0);
        check("rst_wrreg", {27'd0, bus.wrreg}, 32'd0);
        check("rst_wrdata", bus.wrdata, 32'd0);
        check("rst_stall", {31'd0, bus.stall_req}, 32'd0);
        rst_n = 1'b1;
        drive_pipe(1'b0, 5'd0, 32'h0);
        #1;
        check("rel_mc_ready", {31'd0, bus.mc_ready}, 32'd1);
        tick();
        check("rel_regwrite", {31'd0, bus.regwrite}, 32'd0);

        // pipe only
        drive_pipe(1'b1, 5'd8, 32'hDEADBEEF);
        tick();
        check("pipe_regwrite", {31'd0, bus.regwrite}, 32'd1);
        check("pipe_wrreg", {27'd0, bus.wrreg}, 32'd8);
        check("pipe_wrdata", bus.wrdata, 32'hDEADBEEF);
        drive_pipe(1'b0, 5'd0, 32'h0);
        tick();
        check("pipe_drop", {31'd0, bus.regwrite}, 32'd0);
        check("pipe_hold", {27'd0, bus.wrreg}, 32'd8);

        // idle drain
        drive_mc(1'b1, 5'd2, 32'h12345678);
        tick();
        drive_mc(1'b0, 5'd0, 32'h0);
        check("drain_pend", bus.pend_mask, 32'h4);
        check("drain_no_wr", {31'd0, bus.regwrite}, 32'd0);
        tick();
        check("drain_regwrite", {31'd0, bus.regwrite}, 32'd1);
        check("drain_wrreg", {27'd0, bus.wrreg}, 32'd2);
        check("drain_wrdata", bus.wrdata, 32'h12345678);
        check("drain_pend0", bus.pend_mask, 32'd0);

        // full FIFO under continuous pipeline writes
        drive_pipe(1'b1, 5'd3, 32'h33);
        drive_mc(1'b1, 5'd9, 32'h99);
        tick();
        drive_mc(1'b1, 5'd10, 32'hAA);
        tick();
        drive_mc(1'b1, 5'd11, 32'hBB);
        check("full_ready", {31'd0, bus.mc_ready}, 32'd0);
        check("full_pend", bus.pend_mask, 32'h600);
        tick();
        check("full_ready_held", {31'd0, bus.mc_ready}, 32'd0);
        check("full_pipe_wr", {27'd0, bus.wrreg}, 32'd3);
        drive_pipe(1'b0, 5'd0, 32'h0);
        tick();
        check("full_pop1", {27'd0, bus.wrreg}, 32'd9);
        check("full_pop1_data", bus.wrdata, 32'h99);
        check("full_credit", {31'd0, bus.mc_ready}, 32'd1);
        check("full_pend1", bus.pend_mask, 32'h400);
        tick();
        drive_mc(1'b0, 5'd0, 32'h0);
        check("full_pop2", {27'd0, bus.wrreg}, 32'd10);
        check("full_pop2_data", bus.wrdata, 32'hAA);
        check("full_pend2", bus.pend_mask, 32'h800);
        tick();
        check("full_pop3", {27'd0, bus.wrreg}, 32'd11);
        check("full_pend3", bus.pend_mask, 32'd0);
        check("full_no_stall", {31'd0, bus.stall_req}, 32'd0);

        // starvation: one pending entry, pipeline keeps winning
        drive_pipe(1'b1, 5'd6, 32'h66);
        drive_mc(1'b1, 5'd4, 32'h44);
        tick();
        drive_mc(1'b0, 5'd0, 32'h0);
        repeat (3) tick();
        check("starve_3", {31'd0, bus.stall_req}, 32'd0);
        tick();
        check("starve_4", {31'd0, bus.stall_req}, 32'd1);
        tick();
        check("starve_sat", {31'd0, bus.stall_req}, 32'd1);
        drive_pipe(1'b0, 5'd0, 32'h0);
        tick();
        check("starve_pop", {27'd0, bus.wrreg}, 32'd4);
        check("starve_pop_wr", {31'd0, bus.regwrite}, 32'd1);
        check("starve_clear", {31'd0, bus.stall_req}, 32'd0);
        check("starve_pend", bus.pend_mask, 32'd0);

        // $zero on both sources
        drive_pipe(1'b1, 5'd0, 32'hFF);
        drive_mc(1'b1, 5'd0, 32'h77);
        #1;
        check("zero_ready", {31'd0, bus.mc_ready}, 32'd1);
        tick();
        check("zero_no_wr", {31'd0, bus.regwrite}, 32'd0);
        check("zero_pend", bus.pend_mask, 32'd0);
        check("zero_empty", {31'd0, bus.mc_ready}, 32'd1);
        drive_mc(1'b1, 5'd7, 32'h77);
        tick();
        drive_mc(1'b0, 5'd0, 32'h0);
        check("zero_pend7", bus.pend_mask, 32'h80);
        tick();
        check("zero_slot_pop", {27'd0, bus.wrreg}, 32'd7);
        check("zero_slot_wr", {31'd0, bus.regwrite}, 32'd1);

        // reset mid-operation discards buffered entries
        drive_pipe(1'b1, 5'd13, 32'hD);
        drive_mc(1'b1, 5'd12, 32'hC);
        tick();
        drive_mc(1'b0, 5'd0, 32'h0);
        check("mid_pend", bus.pend_mask, 32'h1000);
        rst_n = 1'b0;
        tick();
        check("mid_rst_pend", bus.pend_mask, 32'd0);
        check("mid_rst_wr", {31'd0, bus.regwrite}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.mc_ready}, 32'd0);
        drive_pipe(1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        tick();
        check("mid_after_wr", {31'd0, bus.regwrite}, 32'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
